dynamic_multi_bit_sreg: RTL



---
 rtl/sreg_pkg.sv | 19 +
 rtl/sreg_storage.sv | 34 +++
 rtl/dynamic_multi_bit_sreg.sv | 88 ++++++++
 3 files changed

// File: rtl/sreg_pkg.sv
// Shared helpers and defaults for the dynamic multi-bit shift register.
package sreg_pkg;

    // Default synthesis style for the storage array (shift-register LUTs).
    localparam string SRL_STYLE_DEFAULT = "srl";

    // Tap address width; never narrower than one bit.
    function automatic int unsigned sreg_aw(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Fill count width: one more bit than the address so the count can reach DEPTH.
    function automatic int unsigned sreg_fill_w(input int unsigned depth);
        return sreg_aw(depth) + 1;
    endfunction

endpackage

// File: rtl/sreg_storage.sv
// Reset-free, ce-gated shift array with a combinational random-access read port.
module sreg_storage
    import sreg_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 32,
    parameter string       SRL_STYLE_VAL = SRL_STYLE_DEFAULT,
    parameter int unsigned AW            = sreg_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // No reset on purpose so the array can map onto SRL/LUTRAM primitives.
    (* srl_style = SRL_STYLE_VAL *)
    logic [WIDTH-1:0] r_stage [DEPTH] = '{default: '0};

    // Shift the whole chain by one stage when enabled.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Caller guarantees rd_addr < DEPTH.
    assign rd_data = r_stage[rd_addr];

endmodule

// File: rtl/dynamic_multi_bit_sreg.sv
// Shift register with a run-time selectable tap and fill tracking.
module dynamic_multi_bit_sreg
    import sreg_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 32,
    parameter string       SRL_STYLE_VAL = SRL_STYLE_DEFAULT,
    parameter bit          OUT_REG       = 1'b1,
    parameter int unsigned AW            = sreg_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [AW:0]      fill
);

    localparam int unsigned FW = AW + 1;
    typedef logic [FW-1:0] fill_t;

    localparam fill_t           FILL_MAX = FW'(DEPTH);
    localparam logic [AW-1:0]   EA_MAX   = AW'(DEPTH - 1);

    fill_t             r_fill;
    logic [AW-1:0]     w_ea;
    logic [WIDTH-1:0]  w_tap_d;
    logic              w_tap_v;

    // Clamp out-of-range taps to the last stage (only reachable for non-power-of-two DEPTH).
    assign w_ea = (addr > EA_MAX) ? EA_MAX : addr;

    sreg_storage #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .SRL_STYLE_VAL (SRL_STYLE_VAL),
        .AW            (AW)
    ) u_storage (
        .clk     (clk),
        .ce      (ce),
        .din     (din),
        .rd_addr (w_ea),
        .rd_data (w_tap_d)
    );

    // Count stages holding data shifted in since reset/flush, saturating at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
        end else if (flush) begin
            r_fill <= ce ? FW'(1) : '0;
        end else if (ce && (r_fill != FILL_MAX)) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    // Stage ea holds fresh data once more than ea stages are filled.
    assign w_tap_v = (r_fill > FW'(w_ea));
    assign fill    = r_fill;

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] r_dout;
            logic             r_dout_valid;

            // Register the tap every cycle, independent of ce.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout       <= w_tap_d;
                    r_dout_valid <= w_tap_v;
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end else begin : g_out_comb
            assign dout       = w_tap_d;
            assign dout_valid = w_tap_v;
        end
    endgenerate

endmodule
